// File: rtl/sxn_core.sv
// sxn_core: parametrised stack-machine core, the Wishbone-style bus master with ack_i wait states.
// Optional ALU opcodes 6/7/8 (ADD/AND/XOR) are built only when SXN_ALU_EN is defined.
module sxn_core #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned STACK_DEPTH  = 3,
    parameter logic [63:0] RESET_VECTOR = 64'hE000_0000_0000_0000,
    localparam int unsigned AW    = $clog2(XLEN / 8),
    localparam int unsigned LANES = XLEN / 8
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 ack_i,
    input  logic [XLEN-1:0]      dat_i,
    output logic [XLEN-AW-1:0]   adr_o,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [LANES-1:0]     sel_o,
    output logic                 vpa_o,
    output logic [3:0]           opc_o,
    output logic [XLEN-1:0]      dat_o
);

    localparam int unsigned SLOTS = (XLEN == 64) ? 7 : 3;
    localparam int unsigned IRW   = 4 * SLOTS + 4;
    localparam logic [XLEN-1:0]    RV_X    = RESET_VECTOR[63 -: XLEN];
    localparam logic [XLEN-AW-1:0] P_RESET = RV_X[XLEN-1:AW];
    localparam logic [XLEN-AW-1:0] P_ONE   = (XLEN-AW)'(1);

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_LIT8   = 4'd1,
        OP_LIT16  = 4'd2,
        OP_LIT32  = 4'd3,
        OP_STORES = 4'd4,
        OP_LOADS  = 4'd5,
        OP_ADD    = 4'd6,
        OP_AND    = 4'd7,
        OP_XOR    = 4'd8
    } op_e;

    logic [XLEN-AW-1:0] p;
    logic [3:0]         t;
    logic [IRW-1:0]     ir;          // count nibble plus the slot opcodes; the literal field lives in dr
    logic [XLEN-1:0]    dr;
    logic [XLEN-1:0]    stk   [STACK_DEPTH];
    logic [XLEN-1:0]    stk_n [STACK_DEPTH];

    logic [3:0]       cnt;
    logic             is_fetch, bus_ld, bus_st, bus_cyc, advance;
    op_e              op;
    logic [3:0]       sub;
    logic [1:0]       size;
    logic [AW-1:0]    lane;
    logic [LANES-1:0] sel;
    logic [XLEN-1:0]  st_data, ld_shift, ld_val, lit, dr_n;

    assign cnt = ir[IRW-1 -: 4];

    // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        // A zero count is treated like a count of one: nothing to execute, fetch again.
        is_fetch = (t == 4'd0) || (t == cnt) || (cnt == 4'd0) || (t > 4'(SLOTS));
        op = OP_NOP;
        for (int k = 1; k <= SLOTS; k++)
            if (!is_fetch && t == 4'(k)) op = op_e'(ir[IRW-4-4*k +: 4]);
        sub     = dr[3:0];
        size    = (XLEN == 32 && sub[1:0] == 2'd3) ? 2'd2 : sub[1:0];
        bus_st  = (op == OP_STORES) && (sub < 4'd4);
        bus_ld  = (op == OP_LOADS) && (sub < 4'd8);
        bus_cyc = is_fetch || bus_ld || bus_st;
        advance = !bus_cyc || ack_i;
    end

    // Lane steering shared by loads and stores: low address bits below the access size are ignored.
    always_comb begin
        lane = AW'((stk[0][AW-1:0] >> size) << size);
        case (size)
            2'd0:    sel = LANES'(4'h1) << lane;
            2'd1:    sel = LANES'(4'h3) << lane;
            2'd2:    sel = LANES'(4'hF) << lane;
            default: sel = '1;
        endcase
        case (size)
            2'd0:    st_data = {LANES{stk[1][7:0]}};
            2'd1:    st_data = {(LANES/2){stk[1][15:0]}};
            2'd2:    st_data = {(XLEN/32){stk[1][31:0]}};
            default: st_data = stk[1];
        endcase
        ld_shift = dat_i >> {lane, 3'b000};
        case (size)
            2'd0:    ld_val = sub[2] ? XLEN'($signed(ld_shift[7:0]))  : XLEN'(ld_shift[7:0]);
            2'd1:    ld_val = sub[2] ? XLEN'($signed(ld_shift[15:0])) : XLEN'(ld_shift[15:0]);
            2'd2:    ld_val = sub[2] ? XLEN'($signed(ld_shift[31:0])) : XLEN'(ld_shift[31:0]);
            default: ld_val = ld_shift;
        endcase
    end

    always_comb begin
        dr_n = dr;
        lit  = '0;
        for (int i = 0; i < STACK_DEPTH; i++) stk_n[i] = stk[i];
        case (op)
            OP_LIT8, OP_LIT16, OP_LIT32: begin
                if (op == OP_LIT8) begin
                    lit  = XLEN'($signed(dr[7:0]));
                    dr_n = dr >> 8;
                end else if (op == OP_LIT16) begin
                    lit  = XLEN'($signed(dr[15:0]));
                    dr_n = dr >> 16;
                end else begin
                    lit  = XLEN'($signed(dr[31:0]));
                    dr_n = (XLEN == 32) ? '0 : dr >> 32;
                end
                stk_n[0] = lit;
                for (int i = 1; i < STACK_DEPTH; i++) stk_n[i] = stk[i-1];
            end
            OP_STORES: begin
                dr_n = dr >> 4;
                if (bus_st)
                    for (int i = 0; i < STACK_DEPTH; i++)
                        stk_n[i] = stk[(i + 2 < STACK_DEPTH) ? i + 2 : STACK_DEPTH - 1];
            end
            OP_LOADS: begin
                dr_n = dr >> 4;
                if (bus_ld) stk_n[0] = ld_val;
            end
`ifdef SXN_ALU_EN
            OP_ADD, OP_AND, OP_XOR: begin
                if (op == OP_ADD)      stk_n[0] = stk[1] + stk[0];
                else if (op == OP_AND) stk_n[0] = stk[1] & stk[0];
                else                   stk_n[0] = stk[1] ^ stk[0];
                for (int i = 1; i < STACK_DEPTH; i++)
                    stk_n[i] = stk[(i + 1 < STACK_DEPTH) ? i + 1 : STACK_DEPTH - 1];
            end
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            p  <= P_RESET;
            t  <= '0;
            ir <= '0;
            dr <= '0;
            // NOTE: the stack is a few flops rather than a RAM, so it is cleared with everything else.
            for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
        end else if (advance) begin
            if (is_fetch) begin
                ir <= dat_i[XLEN-1 -: IRW];
                dr <= dat_i;
                p  <= p + P_ONE;
                t  <= 4'd1;
            end else begin
                t  <= t + 4'd1;
                dr <= dr_n;
                for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= stk_n[i];
            end
        end
    end

    // Outputs decode straight from state and are forced idle by reset so a stalled cycle drops at once.
    always_comb begin
        cyc_o = reset_ni && bus_cyc;
        stb_o = cyc_o;
        vpa_o = reset_ni && is_fetch;
        we_o  = reset_ni && bus_st;
        opc_o = reset_ni ? op : 4'd0;
        adr_o = '0;
        sel_o = '0;
        dat_o = '0;
        if (reset_ni) begin
            adr_o = (bus_ld || bus_st) ? stk[0][XLEN-1:AW] : p;
            if (is_fetch)               sel_o = '1;
            else if (bus_ld || bus_st)  sel_o = sel;
            if (bus_st)                 dat_o = st_data;
        end
    end

endmodule

// File: tb/tb_sxn_core.sv
// Directed testbench for sxn_core (XLEN=64): reset, literals, wait states, store/load lanes, reset mid-cycle, ALU.
module tb_sxn_core;

    localparam logic [60:0] P0 = 61'h1C00_0000_0000_0000;
    localparam logic [63:0] W_LIT = 64'h3120_0000_0080_017F;
    localparam logic [63:0] W_A   = 64'h4124_0000_0010_03AB;
    localparam logic [63:0] W_B   = 64'h3250_0000_0005_1006;
    localparam logic [63:0] W_C   = 64'h4124_0000_0320_0055;
    localparam logic [63:0] W_ALU = 64'h4116_0000_0000_0705;
    localparam logic [63:0] NEG8001 = 64'hFFFF_FFFF_FFFF_8001;
`ifdef SXN_ALU_EN
    localparam logic [63:0] ALU_Z = 64'd12;
    localparam logic [63:0] ALU_Y = 64'd0;
`else
    localparam logic [63:0] ALU_Z = 64'd7;
    localparam logic [63:0] ALU_Y = 64'd5;
`endif

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        ack_i;
    logic [63:0] dat_i;
    logic [60:0] adr_o;
    logic        cyc_o, stb_o, we_o, vpa_o;
    logic [7:0]  sel_o;
    logic [3:0]  opc_o;
    logic [63:0] dat_o;

    int n_checks = 0;
    int n_fail   = 0;

    sxn_core dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .ack_i    (ack_i),
        .dat_i    (dat_i),
        .adr_o    (adr_o),
        .cyc_o    (cyc_o),
        .stb_o    (stb_o),
        .we_o     (we_o),
        .sel_o    (sel_o),
        .vpa_o    (vpa_o),
        .opc_o    (opc_o),
        .dat_o    (dat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic test_reset();
        reset_ni = 1'b0; ack_i = 1'b1; dat_i = '0;
        repeat (3) @(negedge clk_i);
        n_checks++; if ({cyc_o, stb_o, we_o, vpa_o} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {cyc_o, stb_o, we_o, vpa_o}); end
        n_checks++; if (sel_o !== 8'h00) begin n_fail++; $display("FAIL reset_sel: got %h want 00", sel_o); end
        n_checks++; if (adr_o !== 61'h0) begin n_fail++; $display("FAIL reset_adr: got %h want 0", adr_o); end
        n_checks++; if ({dat_o, opc_o} !== 68'h0) begin n_fail++; $display("FAIL reset_dat_opc: got %h/%h want 0/0", dat_o, opc_o); end
        n_checks++; if (dut.p !== P0) begin n_fail++; $display("FAIL reset_p: got %h want %h", dut.p, P0); end
        reset_ni = 1'b1;
        #1;
        n_checks++; if (adr_o !== P0) begin n_fail++; $display("FAIL first_fetch_adr: got %h want %h", adr_o, P0); end
        n_checks++; if ({cyc_o, stb_o, vpa_o, we_o} !== 4'b1110) begin n_fail++; $display("FAIL first_fetch_ctrl: got %b want 1110", {cyc_o, stb_o, vpa_o, we_o}); end
        n_checks++; if (sel_o !== 8'hFF) begin n_fail++; $display("FAIL first_fetch_sel: got %h want ff", sel_o); end
    endtask

    task automatic test_literals();
        dat_i = W_LIT;
        @(negedge clk_i);
        n_checks++; if ({opc_o, cyc_o} !== {4'd1, 1'b0}) begin n_fail++; $display("FAIL lit8_slot: got opc %0d cyc %b want 1/0", opc_o, cyc_o); end
        n_checks++; if ({dut.p, dut.t} !== {P0 + 61'd1, 4'd1}) begin n_fail++; $display("FAIL fetch_update: got p %h t %0d", dut.p, dut.t); end
        @(negedge clk_i);
        n_checks++; if (opc_o !== 4'd2) begin n_fail++; $display("FAIL lit16_slot: got %0d want 2", opc_o); end
        n_checks++; if (dut.stk[0] !== 64'h7F) begin n_fail++; $display("FAIL lit8_push: got %h want 7f", dut.stk[0]); end
        @(negedge clk_i);
        n_checks++; if (dut.stk[0] !== NEG8001) begin n_fail++; $display("FAIL lit16_z: got %h want %h", dut.stk[0], NEG8001); end
        n_checks++; if (dut.stk[1] !== 64'h7F) begin n_fail++; $display("FAIL lit16_y: got %h want 7f", dut.stk[1]); end
        n_checks++; if ({vpa_o, adr_o} !== {1'b1, P0 + 61'd1}) begin n_fail++; $display("FAIL next_fetch: got vpa %b adr %h want 1/%h", vpa_o, adr_o, P0 + 61'd1); end
    endtask

    task automatic test_wait_fetch();
        ack_i = 1'b0; dat_i = W_A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_checks++; if ({cyc_o, vpa_o, adr_o, sel_o} !== {2'b11, P0 + 61'd1, 8'hFF}) begin n_fail++; $display("FAIL fetch_wait_bus %0d: got cyc %b adr %h sel %h", i, cyc_o, adr_o, sel_o); end
            n_checks++; if ({dut.t, dut.p, dut.stk[0]} !== {4'd3, P0 + 61'd1, NEG8001}) begin n_fail++; $display("FAIL fetch_wait_state %0d: got t %0d p %h z %h", i, dut.t, dut.p, dut.stk[0]); end
        end
        ack_i = 1'b1;
        @(negedge clk_i);
        n_checks++; if ({dut.t, dut.p, opc_o} !== {4'd1, P0 + 61'd2, 4'd1}) begin n_fail++; $display("FAIL fetch_ack: got t %0d p %h opc %0d", dut.t, dut.p, opc_o); end
    endtask

    task automatic test_store_byte();
        @(negedge clk_i);
        @(negedge clk_i);
        n_checks++; if ({adr_o, sel_o} !== {61'h200, 8'h08}) begin n_fail++; $display("FAIL store_lane: got adr %h sel %h want 200/08", adr_o, sel_o); end
        n_checks++; if ({cyc_o, we_o, vpa_o, opc_o} !== {3'b110, 4'd4}) begin n_fail++; $display("FAIL store_ctrl: got cyc %b we %b vpa %b opc %0d", cyc_o, we_o, vpa_o, opc_o); end
        n_checks++; if (dat_o !== 64'hABAB_ABAB_ABAB_ABAB) begin n_fail++; $display("FAIL store_data: got %h want abababababababab", dat_o); end
        ack_i = 1'b0;
        @(negedge clk_i);
        n_checks++; if ({adr_o, sel_o, we_o, dat_o} !== {61'h200, 8'h08, 1'b1, 64'hABAB_ABAB_ABAB_ABAB}) begin n_fail++; $display("FAIL store_stall: got adr %h sel %h we %b dat %h", adr_o, sel_o, we_o, dat_o); end
        n_checks++; if ({dut.t, dut.stk[0]} !== {4'd3, 64'h1003}) begin n_fail++; $display("FAIL store_stall_state: got t %0d z %h", dut.t, dut.stk[0]); end
        ack_i = 1'b1;
        @(negedge clk_i);
        n_checks++; if ({dut.stk[0], dut.stk[1], dut.stk[2]} !== {3{NEG8001}}) begin n_fail++; $display("FAIL store_pop2: got %h %h %h", dut.stk[0], dut.stk[1], dut.stk[2]); end
        n_checks++; if ({vpa_o, we_o, adr_o, dat_o} !== {2'b10, P0 + 61'd2, 64'h0}) begin n_fail++; $display("FAIL store_next_fetch: got vpa %b we %b adr %h dat %h", vpa_o, we_o, adr_o, dat_o); end
    endtask

    task automatic test_load_wait();
        dat_i = W_B;
        @(negedge clk_i);
        ack_i = 1'b0; dat_i = '0;
        @(negedge clk_i);
        n_checks++; if (dut.stk[0] !== 64'h1006) begin n_fail++; $display("FAIL lit_ignores_ack: got %h want 1006", dut.stk[0]); end
        n_checks++; if ({opc_o, sel_o, adr_o, we_o, dat_o} !== {4'd5, 8'hC0, 61'h200, 1'b0, 64'h0}) begin n_fail++; $display("FAIL load_bus: got opc %0d sel %h adr %h we %b", opc_o, sel_o, adr_o, we_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_checks++; if ({cyc_o, sel_o, adr_o} !== {1'b1, 8'hC0, 61'h200}) begin n_fail++; $display("FAIL load_wait_bus %0d: got cyc %b sel %h adr %h", i, cyc_o, sel_o, adr_o); end
            n_checks++; if ({dut.t, dut.p, dut.stk[0]} !== {4'd2, P0 + 61'd3, 64'h1006}) begin n_fail++; $display("FAIL load_wait_state %0d: got t %0d p %h z %h", i, dut.t, dut.p, dut.stk[0]); end
        end
        ack_i = 1'b1; dat_i = 64'h8123_0000_0000_0000;
        @(negedge clk_i);
        n_checks++; if (dut.stk[0] !== 64'hFFFF_FFFF_FFFF_8123) begin n_fail++; $display("FAIL load_signed_half: got %h want ffffffffffff8123", dut.stk[0]); end
        n_checks++; if (dut.stk[1] !== NEG8001) begin n_fail++; $display("FAIL load_keeps_y: got %h want %h", dut.stk[1], NEG8001); end
        n_checks++; if ({vpa_o, adr_o} !== {1'b1, P0 + 61'd3}) begin n_fail++; $display("FAIL load_next_fetch: got vpa %b adr %h", vpa_o, adr_o); end
    endtask

    task automatic test_reset_mid_store();
        dat_i = W_C;
        @(negedge clk_i);
        @(negedge clk_i);
        ack_i = 1'b0;
        @(negedge clk_i);
        n_checks++; if ({we_o, sel_o, adr_o, dat_o} !== {1'b1, 8'hFF, 61'h400, 64'h55}) begin n_fail++; $display("FAIL store_dword: got we %b sel %h adr %h dat %h", we_o, sel_o, adr_o, dat_o); end
        @(negedge clk_i);
        n_checks++; if ({cyc_o, dut.t} !== {1'b1, 4'd3}) begin n_fail++; $display("FAIL store_dword_stall: got cyc %b t %0d", cyc_o, dut.t); end
        #2 reset_ni = 1'b0;
        #1;
        n_checks++; if ({cyc_o, stb_o, we_o, sel_o} !== 11'h0) begin n_fail++; $display("FAIL reset_drops_cycle: got cyc %b stb %b we %b sel %h", cyc_o, stb_o, we_o, sel_o); end
        n_checks++; if ({adr_o, dat_o} !== 125'h0) begin n_fail++; $display("FAIL reset_drops_bus: got adr %h dat %h", adr_o, dat_o); end
        @(negedge clk_i);
        ack_i = 1'b1; reset_ni = 1'b1;
        #1;
        n_checks++; if ({vpa_o, cyc_o, adr_o, dut.t} !== {2'b11, P0, 4'd0}) begin n_fail++; $display("FAIL refetch_after_reset: got vpa %b adr %h t %0d", vpa_o, adr_o, dut.t); end
    endtask

    task automatic test_alu();
        dat_i = W_ALU;
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        n_checks++; if ({opc_o, cyc_o} !== {4'd6, 1'b0}) begin n_fail++; $display("FAIL alu_slot: got opc %0d cyc %b want 6/0", opc_o, cyc_o); end
        @(negedge clk_i);
        n_checks++; if (dut.stk[0] !== ALU_Z) begin n_fail++; $display("FAIL alu_z: got %h want %h", dut.stk[0], ALU_Z); end
        n_checks++; if (dut.stk[1] !== ALU_Y) begin n_fail++; $display("FAIL alu_y: got %h want %h", dut.stk[1], ALU_Y); end
    endtask

    initial begin
        test_reset();
        test_literals();
        test_wait_fetch();
        test_store_byte();
        test_load_wait();
        test_reset_mid_store();
        test_alu();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sxn_core.md
Name: sxn_core

Overview:
- Parametrised next-generation stack-machine core; successor to the fixed 64-bit, 7-slot packed-instruction core.
- Generalised over data width (32/64) and register-stack depth.
- Adds true bus wait states: every cycle is held until ack_i.
- Sits as the bus master on the team's Wishbone-style single-master bus (cyc/stb/we/sel, VPA fetch qualifier, opc_o debug tap).

Parameters:
XLEN, 64, data/address width; legal values 32 or 64.
STACK_DEPTH, 3, register-stack entries (z = top, y, x, ...); minimum 3.
RESET_VECTOR, 64'hE000_0000_0000_0000, byte address of first fetch; the upper XLEN bits are used.
Derived (localparam): AW = log2(XLEN/8); SLOTS = 7 for XLEN=64, 3 for XLEN=32.

Ports:
clk_i  in  1  clock, rising edge.
reset_ni  in  1  reset, asynchronous assert, active-low.
ack_i  in  1  bus cycle acknowledge.
dat_i  in  XLEN  read data.
adr_o  out  XLEN-AW  word address, bits [XLEN-1:AW].
cyc_o  out  1  bus cycle active.
stb_o  out  1  equals cyc_o.
we_o  out  1  write enable.
sel_o  out  XLEN/8  byte lane selects.
vpa_o  out  1  cycle is an instruction fetch.
opc_o  out  4  current slot opcode; 0 during fetch.
dat_o  out  XLEN  write data; 0 unless we_o.

Behaviour:
- **Reset.** Clock is clk_i; reset is asynchronous, active-low (reset_ni).
  - While reset_ni=0: cyc_o/stb_o/we_o/vpa_o=0, sel_o=0, adr_o=0, dat_o=0, opc_o=0.
  - Register values held in reset: p=RESET_VECTOR>>AW, t=0, ir=dr=0, stack=0.
  - First edge after release starts a fetch at RESET_VECTOR.
- **Instruction word.**
  - ir[XLEN-1:XLEN-4] = count C.
  - Slot k (1..SLOTS) opcode = ir[XLEN-4-4k+3 : XLEN-4-4k].
  - dr = copy of the word; literals and sub-ops are consumed from dr LSBs; dr shifts right (zero fill).
- **Sequencer (t).**
  - FETCH when t==0 or t==C, or when t>SLOTS: vpa_o=1, sel_o all ones.
  - On ack: ir<=dat_i, dr<=dat_i, p<=p+1, t<=1.
  - Otherwise EXEC slot t, then t<=t+1.
  - Net effect: C=0 or C=1 refetch immediately; C>SLOTS+1 executes all SLOTS slots.
- **Wait states.**
  - Any cycle asserting cyc_o (fetch/load/store) holds all outputs stable.
  - While ack_i=0, that cycle updates no state.
  - Non-bus slots complete in 1 cycle and ignore ack_i.
- **Stack rules.**
  - Push: entries shift down; deepest is lost.
  - Pop n: entries shift up n; vacated deep entries take a copy of the deepest.
- **Opcodes.**
  - 0 NOP.
  - 1/2/3 LIT8/16/32: push sign-extended dr[7:0]/[15:0]/[31:0]; dr>>=8/16/32. For XLEN=32, LIT32 pushes dr[31:0] and dr becomes 0.
  - 4 STORES: sub=dr[3:0], dr>>=4. Address=z, data=y, pop 2.
    - 0 byte: sel=1<<z[AW-1:0], dat_o replicated y[7:0].
    - 1 half: sel=3<<(z aligned to 2).
    - 2 word: sel=15<<(z aligned to 4).
    - 3 dword: all lanes.
  - 5 LOADS: sub=dr[3:0], dr>>=4. Replaces z with lane data.
    - Sub 0-3: unsigned byte/half/word/dword.
    - Sub 4-7: signed byte/half/word/dword.
  - Other opcodes: NOP.
- **Width and sub-op edge cases.**
  - XLEN=32: dword sub-ops behave as word.
  - Unaligned half/word: low address bits are ignored for alignment.
  - Unknown sub-op: nibble consumed, no bus cycle, stack unchanged.
- **Wrap-around.** p wraps modulo 2^(XLEN-AW).
- **Reset mid-cycle.** Reset during a stalled bus cycle drops cyc_o combinationally and abandons the cycle.

Optional Feature:
- Macro: SXN_ALU_EN.
- When defined, adds opcodes:
  - 6 ADD: z<=y+z, mod 2^XLEN.
  - 7 AND: z<=y&z.
  - 8 XOR: z<=y^z.
  - Each pops 1 (y position refilled per the pop rule); single cycle; no bus cycle.
- Undefined: opcodes 6-8 are NOPs; no adder in the netlist.

Test Plan:
- Reset and first fetch, XLEN=64.
  - Stimulus: reset_ni low for 3 cycles, then high, with ack_i=1.
  - Required: cyc_o=0 during reset; first cycle after release has adr_o=61'h1C00_0000_0000_0000, vpa_o=1, sel_o=FF.
- Literals.
  - Stimulus: fetch 64'h3120_0000_0080_017F.
  - Required: after 2 exec cycles y=0x7F, z=64'hFFFF_FFFF_FFFF_8001; next fetch adr_o = previous adr_o + 1.
- Wait states.
  - Stimulus: hold ack_i=0 for 3 cycles during a fetch, then during a load.
  - Required: cyc_o=1 throughout with adr_o/sel_o stable; t, p and stack unchanged until the ack cycle.
- Store byte.
  - Stimulus: z=0x1003, y=0xAB, slot STORES, sub 0.
  - Required: adr_o=0x200, sel_o=8'h08, we_o=1, dat_o=64'hABAB_ABAB_ABAB_ABAB; stack pops 2.
- Signed half load.
  - Stimulus: z=0x1006, dat_i=64'h8123_0000_0000_0000, sub 5.
  - Required: sel_o=8'hC0, z=64'hFFFF_FFFF_FFFF_8123.
- Reset mid-store and ALU.
  - Stimulus: reset_ni falls while a store is stalled.
  - Required: cyc_o drops in the same cycle; refetch from RESET_VECTOR.
  - With SXN_ALU_EN: y=5, z=7, ADD gives z=12.
